// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Sits behind uart_rx: owns the receiver baud rate (changed only between
// frames), parses SYNC/LEN/payload/CHK frames, buffers the payload and
// releases verified payloads on a valid/ready byte stream.
module uart_rx_frame_ctrl #(
  parameter int unsigned CLK_FREQ_HZ   = 48_000_000,
  parameter int unsigned BAUD_DEFAULT  = 115_200,
  parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] i_Baudrate,
  output logic [31:0] o_Baudrate,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Pl_Valid,
  output logic [7:0]  o_Pl_Byte,
  output logic        o_Pl_Last,
  input  logic        i_Pl_Ready,
  output logic        o_Frame_Done,
  output logic        o_Err,
  output logic [2:0]  o_Err_Code,
  output logic [15:0] o_Err_Count,
  output logic        o_Busy
);

  localparam int unsigned AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] RATIO_DEFAULT = 32'(CLK_FREQ_HZ / BAUD_DEFAULT);
  localparam logic [31:0] TIMEOUT_MULT  = 32'(TIMEOUT_CHARS * 10);
  localparam logic [7:0]  MAX_LEN_B     = 8'(MAX_LEN);

  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  wr_idx_reg, wr_idx_next;
  logic [7:0]  rd_ptr_reg, rd_ptr_next;
  logic [31:0] idle_cnt_reg, idle_cnt_next;
  logic [31:0] baud_reg, baud_next;
  logic [31:0] ratio_reg, ratio_next;
  logic        err_reg, err_next;
  logic [2:0]  err_code_reg, err_code_next;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic [7:0]  pl_byte_reg;

  logic [7:0]    buf_mem [0:MAX_LEN-1];
  logic          buf_we;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [31:0] ratio_req;
  logic        baud_ok;
  logic [31:0] timeout_limit;
  logic        handshake;
  logic        is_last;

  // The clocks-per-bit ratio is kept alongside the baud rate so the timeout
  // threshold only needs a constant multiply.
  assign ratio_req     = (i_Baudrate == 32'd0) ? 32'd0 : CLK_FREQ_HZ / i_Baudrate;
  assign baud_ok       = (ratio_req >= 32'd2) && (ratio_req <= 32'd256);
  assign timeout_limit = TIMEOUT_MULT * ratio_reg;

  assign handshake = (state_reg == S_DRAIN) && i_Pl_Ready;
  assign is_last   = (rd_ptr_reg == len_reg - 8'd1);

  assign o_Baudrate   = baud_reg;
  assign o_Pl_Valid   = (state_reg == S_DRAIN);
  assign o_Pl_Byte    = pl_byte_reg;
  assign o_Pl_Last    = o_Pl_Valid && is_last;
  assign o_Frame_Done = handshake && is_last;
  assign o_Err        = err_reg;
  assign o_Err_Code   = err_code_reg;
  assign o_Err_Count  = err_cnt_reg;
  assign o_Busy       = (state_reg != S_IDLE);

  // Next-state, datapath and error decisions for the frame parser.
  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    sum_next      = sum_reg;
    wr_idx_next   = wr_idx_reg;
    rd_ptr_next   = rd_ptr_reg;
    idle_cnt_next = 32'd0;
    baud_next     = baud_reg;
    ratio_next    = ratio_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    buf_we        = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;

    case (state_reg)
      S_IDLE: begin
        if (baud_ok) begin
          baud_next  = i_Baudrate;
          ratio_next = ratio_req;
        end
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_next = S_LEN;
        end
      end

      S_LEN, S_PAYLOAD, S_CHK: begin
        if (i_Rx_DV) begin
          // A byte on the terminal-count cycle still counts as activity.
          case (state_reg)
            S_LEN: begin
              if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                err_next      = 1'b1;
                err_code_next = ERR_LEN;
                state_next    = S_IDLE;
              end else begin
                len_next    = i_Rx_Byte;
                sum_next    = i_Rx_Byte;
                wr_idx_next = 8'd0;
                state_next  = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we   = 1'b1;
              sum_next = sum_reg + i_Rx_Byte;
              if (wr_idx_reg == len_reg - 8'd1) begin
                state_next = S_CHK;
              end else begin
                wr_idx_next = wr_idx_reg + 8'd1;
              end
            end
            default: begin
              if (sum_reg + i_Rx_Byte == 8'd0) begin
                rd_ptr_next = 8'd0;
                rd_en       = 1'b1;
                rd_addr     = '0;
                state_next  = S_DRAIN;
              end else begin
                err_next      = 1'b1;
                err_code_next = ERR_CHK;
                state_next    = S_IDLE;
              end
            end
          endcase
        end else if (idle_cnt_reg + 32'd1 >= timeout_limit) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = S_IDLE;
        end else begin
          idle_cnt_next = idle_cnt_reg + 32'd1;
        end
      end

      S_DRAIN: begin
        if (i_Rx_DV) begin
          err_next      = 1'b1;
          err_code_next = ERR_OVERRUN;
        end
        if (handshake) begin
          if (is_last) begin
            state_next = S_IDLE;
          end else begin
            rd_ptr_next = rd_ptr_reg + 8'd1;
            rd_en       = 1'b1;
            rd_addr     = AW'(rd_ptr_reg + 8'd1);
          end
        end
      end

      default: state_next = S_IDLE;
    endcase

    err_cnt_next = err_cnt_reg;
    if (err_next && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_next = err_cnt_reg + 16'd1;
    end
  end

  // Control and status registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= 8'd0;
      sum_reg      <= 8'd0;
      wr_idx_reg   <= 8'd0;
      rd_ptr_reg   <= 8'd0;
      idle_cnt_reg <= 32'd0;
      baud_reg     <= 32'(BAUD_DEFAULT);
      ratio_reg    <= RATIO_DEFAULT;
      err_reg      <= 1'b0;
      err_code_reg <= 3'd0;
      err_cnt_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      sum_reg      <= sum_next;
      wr_idx_reg   <= wr_idx_next;
      rd_ptr_reg   <= rd_ptr_next;
      idle_cnt_reg <= idle_cnt_next;
      baud_reg     <= baud_next;
      ratio_reg    <= ratio_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (buf_we) begin
      buf_mem[wr_idx_reg[AW-1:0]] <= i_Rx_Byte;
    end
  end

  // Registered buffer read; only advances on load so the byte holds under stall.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pl_byte_reg <= 8'd0;
    end else if (rd_en) begin
      pl_byte_reg <= buf_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frame, error, timeout, baud and
// reset steps followed by randomized frames checked against a stream parser.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  SYNC    = 8'hAA;

  typedef logic [7:0] bq_t [$];

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [31:0] i_Baudrate;
  logic [31:0] o_Baudrate;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Pl_Valid;
  logic [7:0]  o_Pl_Byte;
  logic        o_Pl_Last;
  logic        i_Pl_Ready;
  logic        o_Frame_Done;
  logic        o_Err;
  logic [2:0]  o_Err_Code;
  logic [15:0] o_Err_Count;
  logic        o_Busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err_cnt = 0;
  int fd_cnt = 0;
  bit rand_ready = 1'b0;

  logic [2:0] err_log [$];
  logic [7:0] acc_log [$];
  logic [7:0] exp_pay [$];
  logic [2:0] exp_errs [$];

  uart_rx_frame_ctrl dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Baudrate   (i_Baudrate),
    .o_Baudrate   (o_Baudrate),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_Byte    (i_Rx_Byte),
    .o_Pl_Valid   (o_Pl_Valid),
    .o_Pl_Byte    (o_Pl_Byte),
    .o_Pl_Last    (o_Pl_Last),
    .i_Pl_Ready   (i_Pl_Ready),
    .o_Frame_Done (o_Frame_Done),
    .o_Err        (o_Err),
    .o_Err_Code   (o_Err_Code),
    .o_Err_Count  (o_Err_Count),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  // Observe errors, accepted payload bytes and frame completions mid-cycle.
  always @(negedge i_Clock) begin
    if (!i_Reset) begin
      if (o_Err) err_log.push_back(o_Err_Code);
      if (o_Pl_Valid && i_Pl_Ready) acc_log.push_back(o_Pl_Byte);
      if (o_Frame_Done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
    if (rand_ready) i_Pl_Ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_Byte = b;
    i_Rx_DV   = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Rx_DV = 1'b0;
    if (rand_ready) i_Pl_Ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: hunt for SYNC, then apply the length and mod-256 sum rules.
  function automatic void model_parse(input bq_t q);
    int i;
    int len;
    int sum;
    exp_pay  = {};
    exp_errs = {};
    i = 0;
    while (i < q.size() && q[i] != SYNC) i++;
    if (i + 1 >= q.size()) return;
    len = int'(q[i+1]);
    if (len == 0 || len > MAX_LEN) begin
      exp_errs.push_back(3'd1);
      return;
    end
    sum = len;
    for (int k = 0; k < len; k++) sum += int'(q[i+2+k]);
    sum += int'(q[i+2+len]);
    if (sum % 256 == 0) begin
      for (int k = 0; k < len; k++) exp_pay.push_back(q[i+2+k]);
    end else begin
      exp_errs.push_back(3'd2);
    end
  endfunction

  // kind 0..3 good frame, 4 bad length, 5 bad checksum.
  task automatic run_random_frame(input int idx, input int kind);
    bq_t q;
    int len;
    int eb;
    int ab;
    int fb;
    logic [7:0] s;
    logic [7:0] b;
    q = {};
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h55;
      q.push_back(b);
    end
    q.push_back(SYNC);
    if (kind == 4) begin
      len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      q.push_back(8'(len));
    end else begin
      len = int'($urandom_range(1, MAX_LEN));
      q.push_back(8'(len));
      s = 8'(len);
      for (int k = 0; k < len; k++) begin
        b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
        q.push_back(b);
        s = s + b;
      end
      if (kind == 5) q.push_back(8'(8'd0 - s) + 8'($urandom_range(1, 255)));
      else           q.push_back(8'(8'd0 - s));
    end
    model_parse(q);
    eb = err_log.size();
    ab = acc_log.size();
    fb = fd_cnt;
    foreach (q[i]) begin
      send_byte(q[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int c = 0; c < 400 && o_Busy; c++) tick();
    check("frm_idle", 32'(o_Busy), 32'd0);
    tick();
    tick();
    check("frm_nerr", 32'(err_log.size() - eb), 32'(exp_errs.size()));
    for (int k = 0; k < exp_errs.size() && eb + k < err_log.size(); k++)
      check("frm_code", 32'(err_log[eb+k]), 32'(exp_errs[k]));
    check("frm_nbytes", 32'(acc_log.size() - ab), 32'(exp_pay.size()));
    for (int k = 0; k < exp_pay.size() && ab + k < acc_log.size(); k++)
      check("frm_byte", 32'(acc_log[ab+k]), 32'(exp_pay[k]));
    check("frm_done", 32'(fd_cnt - fb), (exp_pay.size() > 0) ? 32'd1 : 32'd0);
    exp_err_cnt += exp_errs.size();
    check("frm_errcnt", 32'(o_Err_Count), 32'(exp_err_cnt));
    $display("frame %0d kind=%0d len=%0d bytes=%0d errs=%0d", idx, kind, len,
             exp_pay.size(), exp_errs.size());
  endtask

  initial begin
    int hit;
    int pbusy;
    int hbusy;
    int hcode;
    int eb;
    int ab;
    bit stalled;
    logic [7:0] s_byte;
    logic s_last;
    logic [7:0] pay [4];
    logic [7:0] s;

    i_Reset    = 1'b1;
    i_Baudrate = 32'd115_200;
    i_Rx_DV    = 1'b0;
    i_Rx_Byte  = 8'd0;
    i_Pl_Ready = 1'b1;

    // Reset values
    repeat (3) tick();
    check("rst_baud", o_Baudrate, 32'd115_200);
    check("rst_valid", 32'(o_Pl_Valid), 32'd0);
    check("rst_byte", 32'(o_Pl_Byte), 32'd0);
    check("rst_last", 32'(o_Pl_Last), 32'd0);
    check("rst_done", 32'(o_Frame_Done), 32'd0);
    check("rst_err", 32'(o_Err), 32'd0);
    check("rst_code", 32'(o_Err_Code), 32'd0);
    check("rst_cnt", 32'(o_Err_Count), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    i_Reset = 1'b0;
    repeat (3) tick();
    check("baud_default_held", o_Baudrate, 32'd115_200);

    // Good frame AA 03 11 22 33 97, ready high
    send_byte(8'hAA); tick(); tick();
    send_byte(8'h03); tick(); tick();
    send_byte(8'h11); tick();
    send_byte(8'h22); tick();
    send_byte(8'h33); tick();
    check("good_novalid_before_chk", 32'(o_Pl_Valid), 32'd0);
    send_byte(8'h97);
    check("good_v0", 32'(o_Pl_Valid), 32'd1);
    check("good_b0", 32'(o_Pl_Byte), 32'h11);
    check("good_l0", 32'(o_Pl_Last), 32'd0);
    tick();
    check("good_b1", 32'(o_Pl_Byte), 32'h22);
    check("good_l1", 32'(o_Pl_Last), 32'd0);
    tick();
    check("good_b2", 32'(o_Pl_Byte), 32'h33);
    check("good_l2", 32'(o_Pl_Last), 32'd1);
    check("good_done", 32'(o_Frame_Done), 32'd1);
    tick();
    check("good_v_drop", 32'(o_Pl_Valid), 32'd0);
    check("good_busy_drop", 32'(o_Busy), 32'd0);
    check("good_errcnt", 32'(o_Err_Count), 32'd0);
    $display("directed good frame AA 03 11 22 33 97");

    // Bad checksum AA 02 01 02 00
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    check("chk_err", 32'(o_Err), 32'd1);
    check("chk_code", 32'(o_Err_Code), 32'd2);
    check("chk_novalid", 32'(o_Pl_Valid), 32'd0);
    exp_err_cnt = 1;
    check("chk_cnt", 32'(o_Err_Count), 32'd1);
    tick();
    check("chk_err_pulse", 32'(o_Err), 32'd0);
    check("chk_idle", 32'(o_Busy), 32'd0);
    $display("directed bad checksum AA 02 01 02 00");
    run_random_frame(0, 0);

    // Leading garbage, then length errors
    send_byte(8'h00);
    check("garb_00", 32'(o_Err), 32'd0);
    send_byte(8'hFF);
    check("garb_ff", 32'(o_Err), 32'd0);
    send_byte(8'hAA);
    check("garb_sync", 32'(o_Busy), 32'd1);
    send_byte(8'h00);
    check("len0_err", 32'(o_Err), 32'd1);
    check("len0_code", 32'(o_Err_Code), 32'd1);
    tick();
    send_byte(8'hAA);
    send_byte(8'h11);
    check("len17_err", 32'(o_Err), 32'd1);
    check("len17_code", 32'(o_Err_Code), 32'd1);
    exp_err_cnt += 2;
    check("len_cnt", 32'(o_Err_Count), 32'(exp_err_cnt));
    tick();
    $display("directed length errors AA 00, AA 11");

    // Baud configuration in idle
    i_Baudrate = 32'd1_000_000;
    tick(); tick();
    check("baud_load", o_Baudrate, 32'd1_000_000);
    i_Baudrate = 32'd100;
    repeat (3) tick();
    check("baud_ignore_100", o_Baudrate, 32'd1_000_000);
    i_Baudrate = 32'd1_000_000;
    tick();

    // Timeout at 1 Mbaud with a baud request arriving mid-frame
    send_byte(8'hAA);
    i_Baudrate = 32'd2_000_000;
    tick();
    check("baud_frozen_len", o_Baudrate, 32'd1_000_000);
    send_byte(8'h02);
    send_byte(8'h01);
    check("baud_frozen_pl", o_Baudrate, 32'd1_000_000);
    hit = 0; pbusy = 1; hbusy = 1; hcode = 0;
    for (int k = 1; k <= 2100; k++) begin
      tick();
      if (o_Err) begin
        hit = k;
        hcode = int'(o_Err_Code);
        hbusy = int'(o_Busy);
        break;
      end
      pbusy = int'(o_Busy);
    end
    check("to_cycle", 32'(hit), 32'd1920);
    check("to_code", 32'(hcode), 32'd3);
    check("to_busy_fall", 32'(hbusy), 32'd0);
    check("to_busy_before", 32'(pbusy), 32'd1);
    exp_err_cnt++;
    check("to_cnt", 32'(o_Err_Count), 32'(exp_err_cnt));
    tick();
    check("baud_after_idle", o_Baudrate, 32'd2_000_000);
    i_Baudrate = 32'd1_000_000;
    tick(); tick();
    $display("directed timeout after %0d cycles", hit);

    // Backpressure with an overrun byte injected during the drain
    s = 8'h04;
    for (int k = 0; k < 4; k++) begin
      pay[k] = 8'($urandom);
      s = s + pay[k];
    end
    ab = acc_log.size();
    eb = fd_cnt;
    send_byte(8'hAA);
    send_byte(8'h04);
    for (int k = 0; k < 4; k++) send_byte(pay[k]);
    send_byte(8'(8'd0 - s));
    check("bp_valid", 32'(o_Pl_Valid), 32'd1);
    for (int j = 0; j < 40 && o_Pl_Valid; j++) begin
      i_Pl_Ready = (j % 2 == 0);
      if (j == 1) begin
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = 8'($urandom);
      end
      #1;
      if (o_Pl_Last && i_Pl_Ready) check("bp_done", 32'(o_Frame_Done), 32'd1);
      s_byte  = o_Pl_Byte;
      s_last  = o_Pl_Last;
      stalled = !i_Pl_Ready;
      @(posedge i_Clock);
      #1;
      i_Rx_DV = 1'b0;
      if (stalled) begin
        check("bp_hold_valid", 32'(o_Pl_Valid), 32'd1);
        check("bp_hold_byte", 32'(o_Pl_Byte), 32'(s_byte));
        check("bp_hold_last", 32'(o_Pl_Last), 32'(s_last));
      end
      if (j == 1) begin
        check("ovr_err", 32'(o_Err), 32'd1);
        check("ovr_code", 32'(o_Err_Code), 32'd4);
      end
    end
    check("bp_end", 32'(o_Pl_Valid), 32'd0);
    tick();
    check("bp_nbytes", 32'(acc_log.size() - ab), 32'd4);
    for (int k = 0; k < 4 && ab + k < acc_log.size(); k++)
      check("bp_order", 32'(acc_log[ab+k]), 32'(pay[k]));
    check("bp_fd", 32'(fd_cnt - eb), 32'd1);
    exp_err_cnt++;
    check("bp_cnt", 32'(o_Err_Count), 32'(exp_err_cnt));
    $display("directed backpressure frame with overrun");

    // Randomized frames with random ready
    rand_ready = 1'b1;
    for (int f = 1; f <= 24; f++) run_random_frame(f, int'($urandom_range(0, 5)));
    rand_ready = 1'b0;
    i_Pl_Ready = 1'b1;
    tick();

    // Reset in the middle of a payload
    i_Baudrate = 32'd115_200;
    send_byte(8'hAA);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_busy", 32'(o_Busy), 32'd1);
    #2 i_Reset = 1'b1;
    #1;
    check("mrst_baud", o_Baudrate, 32'd115_200);
    check("mrst_busy", 32'(o_Busy), 32'd0);
    check("mrst_valid", 32'(o_Pl_Valid), 32'd0);
    check("mrst_err", 32'(o_Err), 32'd0);
    check("mrst_code", 32'(o_Err_Code), 32'd0);
    check("mrst_cnt", 32'(o_Err_Count), 32'd0);
    check("mrst_byte", 32'(o_Pl_Byte), 32'd0);
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    eb = err_log.size();
    repeat (5) tick();
    check("mrst_no_err", 32'(err_log.size() - eb), 32'd0);
    check("mrst_cnt_after", 32'(o_Err_Count), 32'd0);
    check("mrst_idle", 32'(o_Busy), 32'd0);
    $display("directed reset during payload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame-level controller placed directly behind `uart_rx`. It supplies the receiver's baud-rate configuration and only changes it between frames. It parses the received byte stream into length-prefixed, checksummed frames and buffers each payload. Verified payloads are released downstream over a valid/ready byte stream; bad frames are discarded and flagged.

## Interface
- `CLK_FREQ_HZ`, default 48_000_000: `i_Clock` frequency, used for timeout scaling.
- `BAUD_DEFAULT`, default 115_200: `o_Baudrate` value after reset.
- `SYNC_BYTE`, default 8'hAA: frame start marker.
- `MAX_LEN`, default 16: maximum payload length in bytes (1..255).
- `TIMEOUT_CHARS`, default 4: idle character times allowed inside a frame before it is aborted.
- `i_Clock`  in  1  system clock.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Baudrate`  in  32  requested baud rate.
- `o_Baudrate`  out  32  baud rate driven to `uart_rx`.
- `i_Rx_DV`  in  1  one-cycle byte strobe from `uart_rx`.
- `i_Rx_Byte`  in  8  received byte, valid with `i_Rx_DV`.
- `o_Pl_Valid`  out  1  payload byte valid.
- `o_Pl_Byte`  out  8  payload byte.
- `o_Pl_Last`  out  1  marks the final payload byte of a frame.
- `i_Pl_Ready`  in  1  downstream accepts the byte.
- `o_Frame_Done`  out  1  one-cycle pulse on acceptance of the last payload byte.
- `o_Err`  out  1  one-cycle error pulse.
- `o_Err_Code`  out  3  error code, valid with `o_Err`: 1 bad length, 2 checksum, 3 timeout, 4 overrun.
- `o_Err_Count`  out  16  saturating error counter.
- `o_Busy`  out  1  high in every state except S_IDLE.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
  - Frame is good when (LEN + all payload bytes + CHK) mod 256 == 0.
- States and transitions:
  - S_IDLE: hunt for sync. A byte equal to `SYNC_BYTE` goes to S_LEN. Any other byte is dropped silently, with no error.
  - S_LEN: LEN = 0 or LEN > `MAX_LEN` raises error 1 and returns to S_IDLE. Otherwise store LEN, initialise the running sum to LEN, and go to S_PAYLOAD.
  - S_PAYLOAD: write each byte to the buffer at index 0..LEN-1 and add it to the sum. After byte LEN, go to S_CHK. Bytes equal to `SYNC_BYTE` are treated as plain data here.
  - S_CHK: add CHK to the sum. Sum == 0 goes to S_DRAIN. Otherwise raise error 2 and return to S_IDLE; the buffer is discarded.
  - S_DRAIN: present buffer[0..LEN-1] in order. Advance on `o_Pl_Valid && i_Pl_Ready`. The last handshake pulses `o_Frame_Done` and returns to S_IDLE.
    - A byte arriving on `i_Rx_DV` in this state is dropped and raises error 4; the drain continues.
- Timeout:
  - A 32-bit idle counter runs in S_LEN, S_PAYLOAD and S_CHK, and clears on every `i_Rx_DV`.
  - When it reaches TIMEOUT_CHARS*10*(CLK_FREQ_HZ/`o_Baudrate`), raise error 3 and return to S_IDLE.
  - The counter is held at 0 in S_IDLE and S_DRAIN.
- Baud configuration:
  - In S_IDLE only, `o_Baudrate` loads `i_Baudrate` every cycle, provided CLK_FREQ_HZ/`i_Baudrate` lies in 2..256. Otherwise the previous value is held.
  - `o_Baudrate` is frozen in all other states.
- Error counter: `o_Err_Count` increments on every `o_Err` pulse and saturates at 16'hFFFF.
- Buffer: MAX_LEN x 8 register array or inferred RAM.

## Timing
- Reset values:
  - `o_Baudrate` = `BAUD_DEFAULT`.
  - `o_Pl_Valid`, `o_Pl_Last`, `o_Frame_Done`, `o_Err`, `o_Busy` = 0.
  - `o_Pl_Byte` = 0, `o_Err_Code` = 0, `o_Err_Count` = 0.
  - State = S_IDLE.
- Reset mid-frame or mid-drain: the frame is discarded, with no error pulse and no count.
- State changes take effect the cycle after the `i_Rx_DV` that causes them.
- `o_Err` and `o_Err_Code` are registered: they appear one cycle after the offending byte or the timeout cycle.
- `o_Pl_Valid` with buffer[0] appears one cycle after the CHK byte strobe.
- `o_Pl_Valid`, `o_Pl_Byte` and `o_Pl_Last` are held stable while `i_Pl_Ready` = 0.
- With `i_Pl_Ready` held high, the drain sustains 1 byte/cycle.
- After the final handshake, `o_Pl_Valid` drops in the next cycle.
- `o_Frame_Done` and `o_Pl_Last` are asserted together with the final handshake.
- `i_Rx_DV` and timeout terminal count in the same cycle: the byte wins and no timeout is raised.
- Error 4 and the final drain handshake in the same cycle: both occur.

## Test plan
- Good frame: AA 03 11 22 33 97 (sum = 0), `i_Pl_Ready` = 1 -> payload 11, 22, 33 on consecutive cycles, last on 33, `o_Frame_Done` = 1, `o_Err_Count` = 0.
- Bad checksum: AA 02 01 02 00 -> `o_Err` with code 2, no `o_Pl_Valid`, `o_Err_Count` = 1. A following good frame is then delivered intact.
- Length errors: AA 00 and AA 11 (MAX_LEN = 16) -> code 1 each time, `o_Err_Count` = 2. Leading garbage 00 FF before AA produces no error.
- Timeout at 1 Mbaud, 48 MHz: AA 02 01, then silence -> code 3 exactly 4*10*48 = 1920 cycles after the strobe of byte 01, `o_Busy` falls.
- Backpressure/overrun: good 4-byte frame with `i_Pl_Ready` toggling 1/0, plus a new byte injected during the drain -> order preserved, outputs stable while stalled, code 4 raised.
- Baud/reset:
  - `i_Baudrate` changed mid-frame -> `o_Baudrate` is unchanged until S_IDLE.
  - `i_Baudrate` = 100 (ratio > 256) -> ignored.
  - `i_Reset` pulsed during S_PAYLOAD -> all outputs at reset values and `o_Baudrate` = 115200.
